// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch front end: credit-gated request issue, response FIFO, redirect flush
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_rsp_valid,
  input  logic [XLEN-1:0] i_mem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic [XLEN-1:0] o_fetch_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_inst [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [OW-1:0]   live;
  logic [OW-1:0]   drop;

  logic            fifo_credit;
  logic            mem_credit;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_pc;
  logic            unused_redirect_low;

  assign unused_redirect_low = ^i_redirect_pc[1:0];

  // Live requests reserve FIFO slots so a returning response always has room.
  always_comb begin
    fifo_credit     = (SW'(count) + SW'(live)) < SW'(DEPTH);
    mem_credit      = (SW'(live) + SW'(drop)) < SW'(MAX_OUTSTANDING);
    redirect_pc     = {i_redirect_pc[XLEN-1:2], 2'b00};
    o_mem_req_valid = !i_reset && !i_redirect_valid && fifo_credit && mem_credit;
    o_mem_req_addr  = fetch_pc;
    o_fetch_pc      = fetch_pc;
    req_fire        = o_mem_req_valid && i_mem_req_ready;
    rsp_drop        = i_mem_rsp_valid && (drop != '0);
    rsp_keep        = i_mem_rsp_valid && (drop == '0);
    o_inst_valid    = !i_reset && (count != '0);
    o_inst          = fifo_inst[head];
    o_inst_pc       = fifo_pc[head];
    push            = rsp_keep && !i_redirect_valid && !i_reset;
    pop             = o_inst_valid && i_inst_ready && !i_redirect_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      live     <= '0;
      drop     <= '0;
    end else if (i_redirect_valid) begin
      // Everything in flight becomes garbage; a same-cycle response retires one of them.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      live     <= '0;
      drop     <= drop + live - OW'(i_mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) begin
        rsp_pc <= rsp_pc + XLEN'(4);
        tail   <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      live  <= live + OW'(req_fire) - OW'(rsp_keep);
      drop  <= drop - OW'(rsp_drop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc[tail]   <= rsp_pc;
      fifo_inst[tail] <= i_mem_rsp_data;
    end
  end

  rsp_has_owner: assert property (@(posedge i_clk) disable iff (i_reset)
    i_mem_rsp_valid |-> (live != '0 || drop != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a fixed-latency in-order memory model
module tb_fetch_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] fetch_pc;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MO), .RESET_PC('0)) dut (
    .i_clk(clk), .i_reset(rst),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready), .o_mem_req_addr(mem_req_addr),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_data(mem_rsp_data),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready), .o_inst(inst), .o_inst_pc(inst_pc),
    .o_fetch_pc(fetch_pc)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pop_pcs[$];
  logic [31:0] exp_fetch_pc;
  int n_checks = 0;
  int n_pass = 0;
  int cyc, lat, nfire, first_acc, first_val;
  logic ready_ctl, iready_ctl, redir_ctl;
  logic [31:0] redir_pc_ctl;
  logic s_req_valid, s_inst_valid, s_rsp_valid;
  logic [31:0] s_fetch_pc, s_fire_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    mem_req_ready  = ready_ctl;
    inst_ready     = iready_ctl;
    redirect_valid = redir_ctl;
    redirect_pc    = redir_pc_ctl;
    #1;
    s_req_valid  = mem_req_valid;
    s_inst_valid = inst_valid;
    s_rsp_valid  = mem_rsp_valid;
    s_fetch_pc   = fetch_pc;
    if (redirect_valid) check("req_in_redirect", {31'd0, mem_req_valid}, 0);
    if (inst_valid) begin
      check("stale_inst", {31'd0, exp_q.size() == 0}, 0);
      if (first_val < 0) first_val = cyc;
    end
    if (inst_valid && inst_ready && !redirect_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("inst_pc", inst_pc, e);
      check("inst_data", inst, mem_word(e));
      pop_pcs.push_back(inst_pc);
    end
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", mem_req_addr, exp_fetch_pc);
      mem_q.push_back('{addr: mem_req_addr, due: cyc + lat});
      exp_q.push_back(mem_req_addr);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      s_fire_addr = mem_req_addr;
      nfire++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (mem_rsp_valid) void'(mem_q.pop_front());
    if (redirect_valid) begin
      exp_q.delete();
      exp_fetch_pc = {redirect_pc[31:2], 2'b00};
    end
    check("inflight_bound", {31'd0, mem_q.size() > MO}, 0);
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    mem_req_ready = 1'b0; inst_ready = 1'b0;
    #1;
    check("rst_req_valid", {31'd0, mem_req_valid}, 0);
    check("rst_inst_valid", {31'd0, inst_valid}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_q.delete(); exp_q.delete(); pop_pcs.delete();
    exp_fetch_pc = '0; cyc = 0; nfire = 0; first_acc = -1; first_val = -1;
    ready_ctl = 1'b1; iready_ctl = 1'b1; redir_ctl = 1'b0; redir_pc_ctl = '0;
    #1;
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_inst_valid_after", {31'd0, inst_valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    s_fire_addr = '0;

    // streaming, latency 1
    do_reset(); lat = 1;
    run(20);
    check("first_valid_latency", first_val - first_acc, 2);
    check("stream_pops", {31'd0, pop_pcs.size() >= 15}, 1);
    if (pop_pcs.size() >= 3) begin
      check("stream_pc0", pop_pcs[0], 32'h0);
      check("stream_pc2", pop_pcs[2], 32'h8);
    end

    // decode stalled fills exactly DEPTH slots
    do_reset(); lat = 1; iready_ctl = 1'b0;
    run(10);
    check("stall_reqs", nfire, DEPTH);
    check("stall_gate", {31'd0, s_req_valid}, 0);
    check("stall_head_valid", {31'd0, s_inst_valid}, 1);
    iready_ctl = 1'b1; n = nfire;
    step();
    check("release_pop_pc", (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hDEAD, 32'h0);
    for (int i = 0; i < 3 && nfire == n; i++) step();
    check("release_next_req", {31'd0, nfire > n}, 1);
    check("release_next_addr", s_fire_addr, 32'h10);
    run(10);

    // redirect with requests in flight, latency 3
    do_reset(); lat = 3;
    for (int i = 0; i < 10 && nfire < 3; i++) step();
    check("inflight_setup", nfire, 3);
    redir_ctl = 1'b1; redir_pc_ctl = 32'h103;
    step();
    redir_ctl = 1'b0; pop_pcs.delete();
    step();
    check("redir_fetch_pc", s_fetch_pc, 32'h100);
    check("redir_fifo_empty", {31'd0, s_inst_valid}, 0);
    for (int i = 0; i < 30 && pop_pcs.size() == 0; i++) step();
    check("redir_first_pc", (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hDEAD, 32'h100);
    run(10);

    // redirect coinciding with a response and a pop
    do_reset(); lat = 1;
    run(6);
    redir_ctl = 1'b1; redir_pc_ctl = 32'h200;
    step();
    check("coinc_rsp", {31'd0, s_rsp_valid}, 1);
    check("coinc_pop", {31'd0, s_inst_valid}, 1);
    redir_ctl = 1'b0; pop_pcs.delete();
    step();
    check("coinc_empty", {31'd0, s_inst_valid}, 0);
    run(10);
    check("coinc_first_pc", (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hDEAD, 32'h200);

    // address wrap, low redirect bits ignored
    do_reset(); lat = 2;
    redir_ctl = 1'b1; redir_pc_ctl = 32'hFFFF_FFFF;
    step();
    redir_ctl = 1'b0; pop_pcs.delete();
    run(12);
    check("wrap_count", {31'd0, pop_pcs.size() >= 3}, 1);
    if (pop_pcs.size() >= 3) begin
      check("wrap_pc0", pop_pcs[0], 32'hFFFF_FFFC);
      check("wrap_pc1", pop_pcs[1], 32'h0);
      check("wrap_pc2", pop_pcs[2], 32'h4);
    end

    // random backpressure and redirects, latency 5
    do_reset(); lat = 5; pop_pcs.delete();
    for (int i = 0; i < 400; i++) begin
      ready_ctl  = ($urandom_range(3) != 0);
      iready_ctl = ($urandom_range(9) < 7);
      if (redir_ctl && $urandom_range(1) == 0) begin
        redir_pc_ctl = $urandom;
      end else begin
        redir_ctl = ($urandom_range(24) == 0);
        redir_pc_ctl = $urandom;
      end
      step();
    end
    redir_ctl = 1'b0; ready_ctl = 1'b1; iready_ctl = 1'b1;
    run(30);
    check("random_progress", {31'd0, pop_pcs.size() > 50}, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
